// File: rtl/kernel_intr_arbiter_if.sv
// -----------------------------------------------------------------------------
// kernel_intr_arbiter_if
// Action interrupt handshake between the kernel interrupt arbiter and the
// host shell.
//   o_interrupt      arbiter -> shell  interrupt request, held until ack
//   o_interrupt_src  arbiter -> shell  source id, stable while o_interrupt=1
//   i_interrupt_ack  shell -> arbiter  one-cycle acknowledge
// Modports: master = arbiter side, slave = shell side.
// -----------------------------------------------------------------------------
interface kernel_intr_arbiter_if #(
  parameter int SRC_WIDTH = 64
);
  logic                 o_interrupt;
  logic [SRC_WIDTH-1:0] o_interrupt_src;
  logic                 i_interrupt_ack;

  modport master (
    output o_interrupt,
    output o_interrupt_src,
    input  i_interrupt_ack
  );

  modport slave (
    input  o_interrupt,
    input  o_interrupt_src,
    output i_interrupt_ack
  );
endinterface

// File: rtl/kernel_intr_arbiter.sv
// -----------------------------------------------------------------------------
// kernel_intr_arbiter
// Latches rising edges of per-kernel completion levels as pending interrupt
// bits and arbitrates the eligible ones round-robin onto the single action
// interrupt handshake toward the host shell. The register slave supplies the
// mask and W1C clear strobes and reads the pending vector back.
//
// Ports
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   kernel_complete   completion level per kernel (0->1 = one event)
//   i_intr_mask       1 = bit may raise an interrupt
//   i_intr_clr_valid  one-cycle W1C strobe
//   i_intr_clr_bits   bits cleared when i_intr_clr_valid
//   o_intr_pending    latched pending vector (not masked)
//   intr              interrupt handshake (master modport)
//
// Build option
//   KERNEL_INTR_TIMEOUT_EN  when defined, a request left unacknowledged for
//   TIMEOUT_CYCLES cycles is dropped for one cycle and re-raised with the same
//   grant and source. When undefined, a request waits for its ack forever.
// -----------------------------------------------------------------------------
module kernel_intr_arbiter #(
  parameter int                   KERNEL_NUM     = 8,
  parameter int                   SRC_WIDTH      = 64,
  parameter logic [SRC_WIDTH-1:0] INT_SRC_BASE   = '0,
  parameter int                   HOLDOFF_CYCLES = 4,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KERNEL_NUM-1:0] kernel_complete,
  input  logic [KERNEL_NUM-1:0] i_intr_mask,
  input  logic                  i_intr_clr_valid,
  input  logic [KERNEL_NUM-1:0] i_intr_clr_bits,
  output logic [KERNEL_NUM-1:0] o_intr_pending,
  kernel_intr_arbiter_if.master intr
);

  localparam int IDX_W = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam int HO_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  if (KERNEL_NUM < 1 || KERNEL_NUM > 32 || HOLDOFF_CYCLES < 1 ||
      TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("kernel_intr_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLDOFF
`ifdef KERNEL_INTR_TIMEOUT_EN
    , S_RETRY
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [KERNEL_NUM-1:0]  kc_q;
  logic [KERNEL_NUM-1:0]  pending_q, pending_d;
  logic [KERNEL_NUM-1:0]  serviced_q, serviced_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [SRC_WIDTH-1:0]   src_q, src_d;
  logic [HO_W-1:0]        ho_cnt_q, ho_cnt_d;

  logic [KERNEL_NUM-1:0]  rise;
  logic [KERNEL_NUM-1:0]  clr;
  logic [KERNEL_NUM-1:0]  eligible;
  logic [KERNEL_NUM-1:0]  ack_set;
  logic                   found;
  logic [IDX_W-1:0]       pick_idx;

`ifdef KERNEL_INTR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
`endif

  // Event capture, W1C clear and round-robin search over eligible bits.
  always_comb begin
    int j;
    rise     = kernel_complete & ~kc_q;
    clr      = i_intr_clr_valid ? i_intr_clr_bits : '0;
    eligible = pending_q & i_intr_mask & ~serviced_q;
    found    = 1'b0;
    pick_idx = ptr_q;
    j        = 0;
    // Scan from the pointer upward, wrapping, so the first hit is the
    // round-robin winner.
    for (int k = 0; k < KERNEL_NUM; k++) begin
      j = int'(ptr_q) + k;
      if (j >= KERNEL_NUM) j = j - KERNEL_NUM;
      if (!found && eligible[IDX_W'(j)]) begin
        found    = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    ho_cnt_d = ho_cnt_q;
    ack_set  = '0;
`ifdef KERNEL_INTR_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_REQ;
          grant_d = pick_idx;
          src_d   = INT_SRC_BASE + SRC_WIDTH'(pick_idx);
`ifdef KERNEL_INTR_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      S_REQ: begin
        // Mask or clear changes on the granted bit do not retract the
        // request; only the ack (or a timeout) leaves this state.
        if (intr.i_interrupt_ack) begin
          ack_set[grant_q] = 1'b1;
          ptr_d    = (grant_q == IDX_W'(KERNEL_NUM - 1)) ? '0
                                                         : grant_q + IDX_W'(1);
          ho_cnt_d = '0;
          state_d  = S_HOLDOFF;
        end
`ifdef KERNEL_INTR_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_RETRY;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
`ifdef KERNEL_INTR_TIMEOUT_EN
      S_RETRY: begin
        // One low cycle, then the same grant and source are re-raised.
        state_d   = S_REQ;
        tmo_cnt_d = '0;
      end
`endif
      S_HOLDOFF: begin
        if (ho_cnt_q == HO_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          ho_cnt_d = ho_cnt_q + HO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A rising edge wins over a simultaneous clear; the clear still resets
    // the serviced flag so the new event can be delivered.
    pending_d  = (pending_q & ~clr) | rise;
    serviced_d = (serviced_q | ack_set) & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      kc_q       <= '0;
      pending_q  <= '0;
      serviced_q <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      src_q      <= '0;
      ho_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      kc_q       <= kernel_complete;
      pending_q  <= pending_d;
      serviced_q <= serviced_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      src_q      <= src_d;
      ho_cnt_q   <= ho_cnt_d;
    end
  end

`ifdef KERNEL_INTR_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign o_intr_pending       = pending_q;
  assign intr.o_interrupt     = (state_q == S_REQ);
  assign intr.o_interrupt_src = src_q;

endmodule

// File: tb/tb_kernel_intr_arbiter.sv
module tb_kernel_intr_arbiter;

  localparam int          KN      = 8;
  localparam int          SW      = 64;
  localparam logic [63:0] BASE    = 64'h100;
  localparam int          HOLDOFF = 4;
  localparam int          TMO     = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [KN-1:0] kc;
  logic [KN-1:0] mask;
  logic          clr_valid;
  logic [KN-1:0] clr_bits;
  logic [KN-1:0] pending;

  int n_chk  = 0;
  int n_fail = 0;

  kernel_intr_arbiter_if #(.SRC_WIDTH(SW)) intr_bus ();

  kernel_intr_arbiter #(
    .KERNEL_NUM     (KN),
    .SRC_WIDTH      (SW),
    .INT_SRC_BASE   (BASE),
    .HOLDOFF_CYCLES (HOLDOFF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .kernel_complete  (kc),
    .i_intr_mask      (mask),
    .i_intr_clr_valid (clr_valid),
    .i_intr_clr_bits  (clr_bits),
    .o_intr_pending   (pending),
    .intr             (intr_bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_irq(input int limit, output int cyc);
    cyc = 0;
    while (intr_bus.o_interrupt !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic ack_once();
    intr_bus.i_interrupt_ack = 1'b1;
    tick();
    intr_bus.i_interrupt_ack = 1'b0;
  endtask

  task automatic clear(input logic [KN-1:0] b);
    clr_valid = 1'b1;
    clr_bits  = b;
    tick();
    clr_valid = 1'b0;
    clr_bits  = '0;
  endtask

  task automatic pulse(input logic [KN-1:0] b);
    kc = kc | b;
    tick();
    kc = kc & ~b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    kc = '0;
    clr_valid = 1'b0;
    clr_bits = '0;
    intr_bus.i_interrupt_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic quiet(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      seen = seen | intr_bus.o_interrupt;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   grants;
    int   n;
    logic seen;

    rst_n = 1'b0;
    kc = '0;
    mask = 8'hFF;
    clr_valid = 1'b0;
    clr_bits = '0;
    intr_bus.i_interrupt_ack = 1'b0;
    tick();
    tick();
    chk("rst_pending", pending, 0);
    chk("rst_irq", intr_bus.o_interrupt, 0);
    chk("rst_src", intr_bus.o_interrupt_src, 0);
    rst_n = 1'b1;
    tick();

    // Single event on kernel 2.
    kc = 8'h04;
    tick();
    kc = 8'h00;
    chk("t1_pending", pending, 8'h04);
    chk("t1_irq_early", intr_bus.o_interrupt, 0);
    tick();
    chk("t1_irq", intr_bus.o_interrupt, 1);
    chk("t1_src", intr_bus.o_interrupt_src, BASE + 2);
    tick(); tick(); tick();
    chk("t1_irq_held", intr_bus.o_interrupt, 1);
    ack_once();
    chk("t1_irq_after_ack", intr_bus.o_interrupt, 0);
    quiet(15, seen);
    chk("t1_no_reissue", seen, 0);
    clear(8'h04);
    chk("t1_cleared", pending, 0);

    // Three simultaneous events, round-robin from pointer 0.
    do_reset();
    pulse(8'hA1);
    chk("t2_pending", pending, 8'hA1);
    wait_irq(20, cyc);
    chk("t2_irq0", intr_bus.o_interrupt, 1);
    chk("t2_src0", intr_bus.o_interrupt_src, BASE + 0);
    ack_once();
    wait_irq(40, cyc);
    chk("t2_gap0", cyc, HOLDOFF + 1);
    chk("t2_src5", intr_bus.o_interrupt_src, BASE + 5);
    ack_once();
    wait_irq(40, cyc);
    chk("t2_gap1", cyc, HOLDOFF + 1);
    chk("t2_src7", intr_bus.o_interrupt_src, BASE + 7);
    ack_once();
    clear(8'hA1);
    pulse(8'h42);
    wait_irq(40, cyc);
    chk("t2_wrap_src1", intr_bus.o_interrupt_src, BASE + 1);
    ack_once();
    wait_irq(40, cyc);
    chk("t2_wrap_src6", intr_bus.o_interrupt_src, BASE + 6);
    ack_once();
    clear(8'hFF);

    // Masked event stays pending; unmasking raises it.
    mask = 8'h00;
    pulse(8'h08);
    quiet(8, seen);
    chk("t3_pending", pending, 8'h08);
    chk("t3_masked_quiet", seen, 0);
    mask = 8'h08;
    wait_irq(10, cyc);
    chk("t3_irq", intr_bus.o_interrupt, 1);
    chk("t3_src", intr_bus.o_interrupt_src, BASE + 3);
    mask = 8'h00;
    tick(); tick();
    chk("t3_mask_no_retract", intr_bus.o_interrupt, 1);
    clear(8'h08);
    chk("t3_clr_no_retract", intr_bus.o_interrupt, 1);
    chk("t3_clr_pending", pending, 0);
    ack_once();
    clear(8'h08);

    // Rise and clear on the same bit in the same cycle.
    mask = 8'h00;
    pulse(8'h02);
    chk("t4_pre", pending, 8'h02);
    tick();
    kc = 8'h02;
    clr_valid = 1'b1;
    clr_bits = 8'h02;
    tick();
    clr_valid = 1'b0;
    clr_bits = '0;
    kc = 8'h00;
    chk("t4_set_wins", pending, 8'h02);
    clear(8'h02);
    chk("t4_cleared", pending, 0);
    mask = 8'hFF;

    // Level held high produces a single event.
    grants = 0;
    kc = 8'h10;
    for (int i = 0; i < 100; i++) begin
      if (intr_bus.o_interrupt === 1'b1) begin
        grants++;
        ack_once();
      end else begin
        tick();
      end
    end
    chk("t5_one_grant", grants, 1);
    chk("t5_pending", pending, 8'h10);
    clear(8'h10);
    quiet(20, seen);
    chk("t5_no_new_pending", pending, 0);
    chk("t5_no_new_irq", seen, 0);
    kc = 8'h00;

    // Unacknowledged request.
    do_reset();
    pulse(8'h40);
    wait_irq(10, cyc);
    chk("t6_src", intr_bus.o_interrupt_src, BASE + 6);
    n = 0;
`ifdef KERNEL_INTR_TIMEOUT_EN
    while (intr_bus.o_interrupt === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("t6_high_cycles", n, TMO);
    chk("t6_retry_low", intr_bus.o_interrupt, 0);
    tick();
    chk("t6_reraise", intr_bus.o_interrupt, 1);
    chk("t6_reraise_src", intr_bus.o_interrupt_src, BASE + 6);
    ack_once();
    chk("t6_acked", intr_bus.o_interrupt, 0);
    quiet(30, seen);
    chk("t6_serviced", seen, 0);
`else
    while (intr_bus.o_interrupt === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("t6_held_cycles", n, 40);
    chk("t6_still_high", intr_bus.o_interrupt, 1);
    ack_once();
    chk("t6_acked", intr_bus.o_interrupt, 0);
`endif

    // Reset in the middle of a request.
    clear(8'hFF);
    pulse(8'h04);
    wait_irq(10, cyc);
    chk("t7_irq", intr_bus.o_interrupt, 1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_irq", intr_bus.o_interrupt, 0);
    chk("t7_rst_src", intr_bus.o_interrupt_src, 0);
    chk("t7_rst_pending", pending, 0);
    tick();
    rst_n = 1'b1;
    quiet(5, seen);
    chk("t7_quiet_after", seen, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
